sync_fifo_ext: RTL and testbench
================================

# sync_fifo_ext

Parametrised single-clock FIFO, the successor to the basic `fifo` buffer. It supports arbitrary (non power-of-two) depth and a selectable standard or first-word-fall-through read mode. Writes to a full FIFO and reads from an empty one are dropped, and each drop is reported. It also exposes occupancy and threshold flags computed from an explicit count. Used between pipeline stages and peripheral buffers wherever a simple FIFO is needed.

## Interface
- `DATA_WIDTH`, 8: word width, ≥1.
- `DATA_DEPTH`, 1024: storage depth in words, any value ≥2.
- `FWFT`, 0: 0 = standard read mode, 1 = first-word-fall-through.
- `PFULL_NUM`, 1: pfull threshold margin, 0 ≤ value < DATA_DEPTH.
- `PEMPTY_NUM`, 1: pempty threshold, 0 ≤ value < DATA_DEPTH.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  DATA_WIDTH  write data.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read request (standard mode) or head acknowledge (FWFT).
- `dout`  out  DATA_WIDTH  read data.
- `full`  out  1  no write will be accepted.
- `empty`  out  1  no read will be accepted.
- `pfull`  out  1  count ≥ DATA_DEPTH − PFULL_NUM.
- `pempty`  out  1  count ≤ PEMPTY_NUM.
- `count`  out  CW = $clog2(DATA_DEPTH+1)  words held, 0..DATA_DEPTH.
- `overflow`  out  1  one-cycle pulse: a write was dropped.
- `underflow`  out  1  one-cycle pulse: a read was dropped.

## Operation
- Accepted write: `wr_ok = wr_en & ~full`. Accepted read: `rd_ok = rd_en & ~empty`. Both use current-cycle flags.
- Write pointer and read pointer each span 0..DATA_DEPTH−1 and wrap to 0 after DATA_DEPTH−1. Pointers carry no extra wrap bit. Full and empty are derived from `count` only.
- `count` next value = count + wr_ok − rd_ok. Simultaneous accepted read and write leave it unchanged.
- `full` = (count == DATA_DEPTH).
- A write while full is dropped even if a read is accepted in the same cycle. A read while empty is dropped even if a write is accepted in the same cycle.
- `overflow` is registered: high for one cycle after an edge where `wr_en & full`. `underflow` is the same for `rd_en & empty`.
- Standard mode (FWFT=0):
  - `empty` = (count == 0).
  - `dout` loads the head word at the edge where rd_ok, and holds otherwise.
- FWFT mode (FWFT=1):
  - An output register with a valid flag `ov` sits after storage. `count` includes the word held in that register.
  - When `ov`=0 and storage is non-empty, the register prefetches the head word automatically.
  - `empty` = ~ov. `dout` shows the head word while `empty`=0.
  - rd_ok consumes the head. If storage has data, the next word is loaded at the same edge, so back-to-back reads run at full rate. Otherwise `ov` clears.
- All outputs after reset: full=0, empty=1, pfull=(PFULL_NUM ≥ DATA_DEPTH ? 1 : 0, which is 0 for legal values), pempty=1, count=0, overflow=0, underflow=0, dout=0, ov=0. Pointers return to 0.
- Storage contents are not cleared by reset. Reset taken mid-operation discards all words on that edge.

## Timing
- Flags and `count` are registered-state derived, so they reflect accepted operations from the edge after those operations.
- Standard mode:
  - Write to empty FIFO at edge N → empty=0 after N.
  - rd_ok at edge M → dout valid after M (1-cycle read latency).
- FWFT mode:
  - Write to empty FIFO at edge N → empty=0 and dout valid after N+1 (2-cycle fall-through).
  - `count` already reads 1 after N.
- Threshold flags update in the same cycle as `count`.

## Structure
- Package `fifo_pkg`:
  - `fifo_mode_e` enum {FIFO_STD, FIFO_FWFT}.
  - Count-width helper function.
- Sub-module `fifo_sdp_ram`: simple dual-port storage with one write port and one registered read port, sized DATA_DEPTH × DATA_WIDTH. Pointer, count, flag and FWFT logic stay in `sync_fifo_ext`.

## Test plan
- DEPTH=5, STD: write 1..5 → count=5, full=1 and pfull=1 after the 5th write. Read 5 times → dout 1,2,3,4,5, then empty=1, pempty=1.
- DEPTH=5, full: assert wr_en and rd_en together → read returns 1, write is dropped, overflow pulses once, count=4.
- Empty FIFO, STD: rd_en and wr_en(0xAA) together → underflow=1, count=1. The next read returns 0xAA.
- FWFT, DEPTH=4: write 0x11 at edge N → dout=0x11 and empty=0 after N+1. Continuous rd_en with writes of 0x22, 0x33 → one word consumed per cycle, in order.
- Pointer wrap, DEPTH=5: 12 interleaved write/read pairs → data matches a scoreboard and count stays within 0..5.
- Reset mid-operation with count=3: rst_n=0 for one edge → count=0, empty=1, dout=0, and all flags at their reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync_fifo_ext FIFO family.
//   fifo_mode_e : read-mode selector (standard / first-word-fall-through)
//   fifo_cnt_w  : width needed to hold an occupancy of 0..depth
//   fifo_ptr_w  : width needed to address 0..depth-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// -----------------------------------------------------------------------------
// fifo_sdp_ram
// Simple dual-port storage: one write port, one read port with a registered
// output. The array is left uninitialised so it maps onto block RAM; only the
// read data register is reset, which is what lets the FIFO present dout=0
// after reset.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (read register only)
//   we, waddr, wdata write port
//   re, raddr        read request; rdata loads mem[raddr] on the edge
//   rdata            registered read data, holds when re=0
// -----------------------------------------------------------------------------
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1024,
    parameter int AW         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The FIFO never reads and writes the same address on one edge, so no
    // read-during-write behaviour needs to be defined here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ext.sv
// -----------------------------------------------------------------------------
// sync_fifo_ext
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, explicit occupancy count, threshold flags and drop reporting.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   din, wr_en            write data / request (dropped while full)
//   rd_en                 read request (STD) or head acknowledge (FWFT)
//   dout                  read data (STD: loaded on accepted read; FWFT: head)
//   full, empty           acceptance flags
//   pfull, pempty         count >= DEPTH-PFULL_NUM / count <= PEMPTY_NUM
//   count                 words held, including the FWFT output word
//   overflow, underflow   one-cycle pulses after a dropped write / read
// -----------------------------------------------------------------------------
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 1024,
    parameter int FWFT       = 0,
    parameter int PFULL_NUM  = 1,
    parameter int PEMPTY_NUM = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            wr_en,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic                            pfull,
    output logic                            pempty,
    output logic [$clog2(DATA_DEPTH+1)-1:0] count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int CW = fifo_cnt_w(DATA_DEPTH);
    localparam int AW = fifo_ptr_w(DATA_DEPTH);
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] PFULL_THR  = CW'(DATA_DEPTH - PFULL_NUM);
    localparam logic [CW-1:0] PEMPTY_THR = CW'(PEMPTY_NUM);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DATA_DEPTH - 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ov_q, ov_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_ok;
    logic          rd_ok;
    logic          ram_re;
    logic [CW-1:0] stored;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full  = (count_q == DEPTH_C);
    assign empty = (MODE == FIFO_FWFT) ? ~ov_q : (count_q == '0);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Words still inside the RAM; in FWFT mode the head may already sit in
    // the RAM's read register (ov_q), which count includes.
    assign stored = count_q - CW'(ov_q);

    always_comb begin
        ram_re      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
        ov_d        = 1'b0;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;

        if (MODE == FIFO_FWFT) begin
            // The RAM read register doubles as the FWFT output register:
            // refill it whenever it is vacant or being consumed this edge.
            ram_re = (stored != '0) & (~ov_q | rd_ok);
            ov_d   = ram_re | (ov_q & ~rd_ok);
        end else begin
            ram_re = rd_ok;
        end

        if (wr_ok) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (ram_re) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ov_q        <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ov_q        <= ov_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign pfull     = (count_q >= PFULL_THR);
    assign pempty    = (count_q <= PEMPTY_THR);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ext
// Two FIFO instances side by side: a 5-deep standard-mode FIFO and a 4-deep
// FWFT FIFO. A queue-based model of each tracks contents and expected flags.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ext;

    localparam int DW      = 8;
    localparam int S_DEPTH = 5;
    localparam int F_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] s_din, s_dout, f_din, f_dout;
    logic          s_wr, s_rd, s_full, s_empty, s_pfull, s_pempty, s_ovf, s_udf;
    logic          f_wr, f_rd, f_full, f_empty, f_pfull, f_pempty, f_ovf, f_udf;
    logic [2:0]    s_count, f_count;

    sync_fifo_ext #(
        .DATA_WIDTH(DW), .DATA_DEPTH(S_DEPTH), .FWFT(0), .PFULL_NUM(1), .PEMPTY_NUM(1)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
        .dout(s_dout), .full(s_full), .empty(s_empty), .pfull(s_pfull),
        .pempty(s_pempty), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_ext #(
        .DATA_WIDTH(DW), .DATA_DEPTH(F_DEPTH), .FWFT(1), .PFULL_NUM(1), .PEMPTY_NUM(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
        .dout(f_dout), .full(f_full), .empty(f_empty), .pfull(f_pfull),
        .pempty(f_pempty), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state
    logic [DW-1:0] sq[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] sm_dout;
    bit            sm_ovf, sm_udf;
    bit            fm_vis, fm_ovf, fm_udf;

    task automatic do_reset();
        s_wr = 0; s_rd = 0; s_din = '0;
        f_wr = 0; f_rd = 0; f_din = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sq.delete();
        fq.delete();
        sm_dout = '0;
        sm_ovf = 0; sm_udf = 0;
        fm_vis = 0; fm_ovf = 0; fm_udf = 0;
        $display("txn %0d: reset", n_txn);
        n_txn++;
    endtask

    // One clock edge on both FIFOs; the models advance from the pre-edge state.
    task automatic tick(input bit sw, input bit sr, input logic [DW-1:0] sd,
                        input bit fw, input bit fr, input logic [DW-1:0] fd);
        int  s_n, f_n, f_stor;
        bit  s_wok, s_rok, f_wok, f_rok;
        s_n    = sq.size();
        s_wok  = sw && (s_n < S_DEPTH);
        s_rok  = sr && (s_n > 0);
        sm_ovf = sw && (s_n == S_DEPTH);
        sm_udf = sr && (s_n == 0);
        if (s_rok) sm_dout = sq.pop_front();
        if (s_wok) sq.push_back(sd);

        // FWFT: the head becomes visible one edge after it is in storage and
        // the output slot is free (or being freed by a read).
        f_n    = fq.size();
        f_stor = f_n - (fm_vis ? 1 : 0);
        f_wok  = fw && (f_n < F_DEPTH);
        f_rok  = fr && fm_vis;
        fm_ovf = fw && (f_n == F_DEPTH);
        fm_udf = fr && !fm_vis;
        if (f_rok) void'(fq.pop_front());
        if (f_wok) fq.push_back(fd);
        fm_vis = (fm_vis && !f_rok) || (f_stor > 0);

        s_wr = sw; s_rd = sr; s_din = sd;
        f_wr = fw; f_rd = fr; f_din = fd;
        @(posedge clk);
        #1;
        s_wr = 0; s_rd = 0; f_wr = 0; f_rd = 0;
        $display("txn %0d: std wr=%0b rd=%0b din=%02h cnt=%0d dout=%02h | fwft wr=%0b rd=%0b din=%02h cnt=%0d dout=%02h",
                 n_txn, sw, sr, sd, s_count, s_dout, fw, fr, fd, f_count, f_dout);
        n_txn++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (s_count !== 3'd0) begin n_errors++; $display("FAIL reset_s_count got %0d want 0", s_count); end
        n_checks++; if (s_full !== 1'b0)  begin n_errors++; $display("FAIL reset_s_full got %b want 0", s_full); end
        n_checks++; if (s_empty !== 1'b1) begin n_errors++; $display("FAIL reset_s_empty got %b want 1", s_empty); end
        n_checks++; if (s_pfull !== 1'b0) begin n_errors++; $display("FAIL reset_s_pfull got %b want 0", s_pfull); end
        n_checks++; if (s_pempty !== 1'b1) begin n_errors++; $display("FAIL reset_s_pempty got %b want 1", s_pempty); end
        n_checks++; if (s_dout !== 8'h00) begin n_errors++; $display("FAIL reset_s_dout got %02h want 00", s_dout); end
        n_checks++; if ({s_ovf, s_udf} !== 2'b00) begin n_errors++; $display("FAIL reset_s_pulses got %b%b want 00", s_ovf, s_udf); end
        n_checks++; if (f_count !== 3'd0) begin n_errors++; $display("FAIL reset_f_count got %0d want 0", f_count); end
        n_checks++; if (f_empty !== 1'b1) begin n_errors++; $display("FAIL reset_f_empty got %b want 1", f_empty); end
        n_checks++; if (f_dout !== 8'h00) begin n_errors++; $display("FAIL reset_f_dout got %02h want 00", f_dout); end
        n_checks++; if ({f_full, f_pfull, f_pempty, f_ovf, f_udf} !== 5'b00100) begin
            n_errors++; $display("FAIL reset_f_flags got %b%b%b%b%b want 00100", f_full, f_pfull, f_pempty, f_ovf, f_udf);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) tick(1, 0, 8'(i), 0, 0, '0);
        n_checks++; if (s_count !== 3'd5) begin n_errors++; $display("FAIL fill_count got %0d want 5", s_count); end
        n_checks++; if (s_full !== 1'b1)  begin n_errors++; $display("FAIL fill_full got %b want 1", s_full); end
        n_checks++; if (s_pfull !== 1'b1) begin n_errors++; $display("FAIL fill_pfull got %b want 1", s_pfull); end
        for (int i = 1; i <= 5; i++) begin
            tick(0, 1, '0, 0, 0, '0);
            n_checks++; if (s_dout !== 8'(i)) begin n_errors++; $display("FAIL drain_dout[%0d] got %02h want %02h", i, s_dout, 8'(i)); end
        end
        n_checks++; if (s_empty !== 1'b1)  begin n_errors++; $display("FAIL drain_empty got %b want 1", s_empty); end
        n_checks++; if (s_pempty !== 1'b1) begin n_errors++; $display("FAIL drain_pempty got %b want 1", s_pempty); end
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= 5; i++) tick(1, 0, 8'(i), 0, 0, '0);
        tick(1, 1, 8'h66, 0, 0, '0);
        n_checks++; if (s_dout !== 8'h01) begin n_errors++; $display("FAIL fullrw_dout got %02h want 01", s_dout); end
        n_checks++; if (s_ovf !== 1'b1)   begin n_errors++; $display("FAIL fullrw_ovf got %b want 1", s_ovf); end
        n_checks++; if (s_count !== 3'd4) begin n_errors++; $display("FAIL fullrw_count got %0d want 4", s_count); end
        tick(0, 0, '0, 0, 0, '0);
        n_checks++; if (s_ovf !== 1'b0)   begin n_errors++; $display("FAIL fullrw_ovf_pulse got %b want 0", s_ovf); end
        for (int i = 2; i <= 5; i++) begin
            tick(0, 1, '0, 0, 0, '0);
            n_checks++; if (s_dout !== 8'(i)) begin n_errors++; $display("FAIL fullrw_drain[%0d] got %02h want %02h", i, s_dout, 8'(i)); end
        end
    endtask

    task automatic test_empty_rw();
        tick(1, 1, 8'hAA, 0, 0, '0);
        n_checks++; if (s_udf !== 1'b1)   begin n_errors++; $display("FAIL emptyrw_udf got %b want 1", s_udf); end
        n_checks++; if (s_count !== 3'd1) begin n_errors++; $display("FAIL emptyrw_count got %0d want 1", s_count); end
        tick(0, 1, '0, 0, 0, '0);
        n_checks++; if (s_dout !== 8'hAA) begin n_errors++; $display("FAIL emptyrw_dout got %02h want aa", s_dout); end
        n_checks++; if (s_udf !== 1'b0)   begin n_errors++; $display("FAIL emptyrw_udf_pulse got %b want 0", s_udf); end
    endtask

    task automatic test_fwft_latency();
        logic [DW-1:0] exp_seq [3];
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
        tick(0, 0, '0, 1, 0, 8'h11);
        n_checks++; if (f_count !== 3'd1) begin n_errors++; $display("FAIL fwft_count_n got %0d want 1", f_count); end
        n_checks++; if (f_empty !== 1'b1) begin n_errors++; $display("FAIL fwft_empty_n got %b want 1", f_empty); end
        tick(0, 0, '0, 1, 0, 8'h22);
        n_checks++; if (f_empty !== 1'b0) begin n_errors++; $display("FAIL fwft_empty_n1 got %b want 0", f_empty); end
        n_checks++; if (f_dout !== 8'h11) begin n_errors++; $display("FAIL fwft_dout_n1 got %02h want 11", f_dout); end
        tick(0, 0, '0, 1, 0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (f_empty !== 1'b0 || f_dout !== exp_seq[i]) begin
                n_errors++; $display("FAIL fwft_stream[%0d] got empty=%b dout=%02h want empty=0 dout=%02h", i, f_empty, f_dout, exp_seq[i]);
            end
            tick(0, 0, '0, 0, 1, '0);
        end
        n_checks++; if (f_empty !== 1'b1 || f_count !== 3'd0) begin
            n_errors++; $display("FAIL fwft_stream_end got empty=%b count=%0d want empty=1 count=0", f_empty, f_count);
        end
    endtask

    task automatic test_wrap_random();
        bit sw, sr;
        for (int i = 0; i < 3; i++) tick(1, 0, 8'($urandom), 0, 0, '0);
        for (int i = 0; i < 84; i++) begin
            if (i < 24) begin
                sw = (i % 2 == 0); sr = (i % 2 == 1);
            end else begin
                sw = ($urandom_range(1, 0) == 1); sr = ($urandom_range(1, 0) == 1);
            end
            tick(sw, sr, 8'($urandom), 0, 0, '0);
            n_checks++; if (s_count !== 3'(sq.size()) || s_count > 3'd5) begin
                n_errors++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, s_count, sq.size());
            end
            n_checks++; if (s_dout !== sm_dout) begin n_errors++; $display("FAIL wrap_dout[%0d] got %02h want %02h", i, s_dout, sm_dout); end
            n_checks++; if ({s_full, s_empty, s_pfull, s_pempty} !== {sq.size() == 5, sq.size() == 0, sq.size() >= 4, sq.size() <= 1}) begin
                n_errors++; $display("FAIL wrap_flags[%0d] got %b%b%b%b for size %0d", i, s_full, s_empty, s_pfull, s_pempty, sq.size());
            end
            n_checks++; if ({s_ovf, s_udf} !== {sm_ovf, sm_udf}) begin
                n_errors++; $display("FAIL wrap_pulses[%0d] got %b%b want %b%b", i, s_ovf, s_udf, sm_ovf, sm_udf);
            end
        end
    endtask

    task automatic test_fwft_random();
        for (int i = 0; i < 150; i++) begin
            tick(0, 0, '0, ($urandom_range(1, 0) == 1), ($urandom_range(2, 0) != 0), 8'($urandom));
            n_checks++; if (f_count !== 3'(fq.size())) begin n_errors++; $display("FAIL frand_count[%0d] got %0d want %0d", i, f_count, fq.size()); end
            n_checks++; if (f_empty !== !fm_vis) begin n_errors++; $display("FAIL frand_empty[%0d] got %b want %b", i, f_empty, !fm_vis); end
            if (fm_vis) begin
                n_checks++; if (f_dout !== fq[0]) begin n_errors++; $display("FAIL frand_dout[%0d] got %02h want %02h", i, f_dout, fq[0]); end
            end
            n_checks++; if ({f_full, f_pfull, f_pempty} !== {fq.size() == 4, fq.size() >= 3, fq.size() <= 1}) begin
                n_errors++; $display("FAIL frand_flags[%0d] got %b%b%b for size %0d", i, f_full, f_pfull, f_pempty, fq.size());
            end
            n_checks++; if ({f_ovf, f_udf} !== {fm_ovf, fm_udf}) begin
                n_errors++; $display("FAIL frand_pulses[%0d] got %b%b want %b%b", i, f_ovf, f_udf, fm_ovf, fm_udf);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (sq.size() > 0) tick(0, 1, '0, 0, 0, '0);
        for (int i = 0; i < 3; i++) tick(1, 0, 8'(8'h40 + i), 1, 0, 8'(8'h50 + i));
        tick(0, 1, '0, 0, 0, '0);
        tick(1, 0, 8'h77, 0, 0, '0);
        n_checks++; if (s_count !== 3'd3) begin n_errors++; $display("FAIL mid_pre_count got %0d want 3", s_count); end
        do_reset();
        n_checks++; if (s_count !== 3'd0 || s_empty !== 1'b1) begin
            n_errors++; $display("FAIL mid_s_state got count=%0d empty=%b want 0/1", s_count, s_empty);
        end
        n_checks++; if (s_dout !== 8'h00) begin n_errors++; $display("FAIL mid_s_dout got %02h want 00", s_dout); end
        n_checks++; if ({s_full, s_pfull, s_pempty, s_ovf, s_udf} !== 5'b00100) begin
            n_errors++; $display("FAIL mid_s_flags got %b%b%b%b%b want 00100", s_full, s_pfull, s_pempty, s_ovf, s_udf);
        end
        n_checks++; if (f_count !== 3'd0 || f_empty !== 1'b1 || f_dout !== 8'h00) begin
            n_errors++; $display("FAIL mid_f_state got count=%0d empty=%b dout=%02h", f_count, f_empty, f_dout);
        end
        tick(0, 1, '0, 0, 0, '0);
        n_checks++; if (s_udf !== 1'b1 || s_dout !== 8'h00) begin
            n_errors++; $display("FAIL mid_post_read got udf=%b dout=%02h want 1/00", s_udf, s_dout);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_fwft_latency();
        test_wrap_random();
        test_fwft_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
